// File: rtl/sprite_sched_pkg.sv
// sprite_sched_pkg: shared types and constants for the sprite line scheduler.
package sprite_sched_pkg;
  localparam int SPRITE_H = 16;
  localparam int LB_AW = 9;
  typedef enum logic [1:0] {IDLE, SCAN, FETCH, DONE} state_t;
  typedef struct packed {
    logic       en;
    logic       flip;
    logic [5:0] num;
    logic [9:0] x;
    logic [9:0] y;
  } attr_t;
  typedef struct packed {
    logic [5:0]       num;
    logic [LB_AW-1:0] x2;
    logic [2:0]       dy;
    logic             flip;
  } hit_t;
endpackage

// File: rtl/sprite_attr_table.sv
// sprite_attr_table: sprite attribute register file, one write port, one combinational read port.
module sprite_attr_table
  import sprite_sched_pkg::*;
#(
  parameter int NUM_SPRITES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       we,
  input  logic [2:0] wr_idx,
  input  attr_t      wr_data,
  input  logic [2:0] rd_idx,
  output attr_t      rd_data
);
  attr_t mem [NUM_SPRITES];
  always_ff @(posedge clk)
    if (!reset_n)
      for (int i = 0; i < NUM_SPRITES; i++) mem[i] <= '0;
    else if (we)
      mem[wr_idx] <= wr_data;
  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: per-line sprite scan and line-buffer fill.
// Optional horizontal flip enabled by defining SPRITE_SCHED_HFLIP_EN.
module sprite_line_scheduler
  import sprite_sched_pkg::*;
#(
  parameter int NUM_SPRITES  = 8,
  parameter int MAX_PER_LINE = 4
) (
  input  logic             i_Clk,
  input  logic             reset_n,
  input  logic             line_start,
  input  logic [9:0]       next_row,
  input  logic             attr_we,
  input  logic [2:0]       attr_idx,
  input  logic             attr_en,
  input  logic             attr_flip,
  input  logic [5:0]       attr_num,
  input  logic [9:0]       attr_x,
  input  logic [9:0]       attr_y,
  output logic [5:0]       rom_sprite,
  output logic [2:0]       rom_row,
  output logic [2:0]       rom_col,
  input  logic [1:0]       rom_pixel,
  output logic             lb_write,
  output logic [LB_AW-1:0] lb_addr,
  output logic [1:0]       lb_data,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             late
);
  localparam int CW = $clog2(MAX_PER_LINE + 1);
  localparam int PW = MAX_PER_LINE > 1 ? $clog2(MAX_PER_LINE) : 1;
  state_t state;
  attr_t wd, rd;
  hit_t hits [MAX_PER_LINE];
  hit_t cur;
  logic [2:0] idx, col, ccol, rr_q, rc_q;
  logic [5:0] rs_q;
  logic [CW-1:0] hcnt;
  logic [PW-1:0] ptr;
  logic [9:0] dyf;
  logic [LB_AW-1:0] p_addr;
  logic drain, ovf_acc, p_valid, hit, take, issuing, unused_bits;
  assign wd = '{en: attr_en, flip: attr_flip, num: attr_num, x: attr_x, y: attr_y};
  sprite_attr_table #(.NUM_SPRITES(NUM_SPRITES)) u_table (
    .clk(i_Clk), .reset_n(reset_n), .we(attr_we), .wr_idx(attr_idx),
    .wr_data(wd), .rd_idx(idx), .rd_data(rd)
  );
  // Row distance wraps mod 1024 so sprites straddling the top edge still hit.
  assign dyf = next_row - rd.y;
  assign hit = rd.en && dyf < 10'(SPRITE_H);
  assign take = hit && hcnt < CW'(MAX_PER_LINE);
  assign issuing = state == FETCH && !drain;
  assign cur = hits[ptr];
`ifdef SPRITE_SCHED_HFLIP_EN
  assign ccol = cur.flip ? ~col : col;
`else
  assign ccol = col;
`endif
  assign unused_bits = ^{rd.x[0], rd.flip, dyf[0], cur.flip};
  // ROM address follows the fetch counters and holds its last value otherwise.
  assign rom_sprite = issuing ? cur.num : rs_q;
  assign rom_row = issuing ? cur.dy : rr_q;
  assign rom_col = issuing ? ccol : rc_q;
  assign lb_write = p_valid && reset_n && rom_pixel != 2'd0;
  assign lb_addr = p_addr;
  assign lb_data = p_valid ? rom_pixel : 2'd0;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge i_Clk) begin
    if (!reset_n) begin
      state <= IDLE;
      idx <= '0;
      hcnt <= '0;
      ptr <= '0;
      col <= '0;
      drain <= 1'b0;
      ovf_acc <= 1'b0;
      overflow <= 1'b0;
      late <= 1'b0;
      p_valid <= 1'b0;
      p_addr <= '0;
      rs_q <= '0;
      rr_q <= '0;
      rc_q <= '0;
    end else begin
      late <= 1'b0;
      p_valid <= issuing;
      rs_q <= rom_sprite;
      rr_q <= rom_row;
      rc_q <= rom_col;
      if (issuing) p_addr <= cur.x2 + LB_AW'(col);
      if (line_start && state != IDLE) begin
        late <= 1'b1;
        p_valid <= 1'b0;
        state <= SCAN;
        idx <= '0;
        hcnt <= '0;
        ovf_acc <= 1'b0;
      end else begin
        case (state)
          IDLE: if (line_start) begin
            state <= SCAN;
            idx <= '0;
            hcnt <= '0;
            ovf_acc <= 1'b0;
          end
          SCAN: begin
            if (take) begin
              hits[PW'(hcnt)] <= '{num: rd.num, x2: rd.x[9:1], dy: dyf[3:1], flip: rd.flip};
              hcnt <= hcnt + 1'b1;
            end
            if (hit && !take) ovf_acc <= 1'b1;
            idx <= idx + 1'b1;
            if (idx == 3'(NUM_SPRITES - 1)) begin
              state <= (hcnt != '0 || take) ? FETCH : DONE;
              ptr <= PW'(take ? hcnt : hcnt - 1'b1);
              col <= '0;
              drain <= 1'b0;
            end
          end
          FETCH: if (drain) state <= DONE;
          else begin
            col <= col + 1'b1;
            if (col == 3'd7) begin
              if (ptr == '0) drain <= 1'b1;
              else ptr <= ptr - 1'b1;
            end
          end
          default: begin
            overflow <= ovf_acc;
            state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb_sprite_line_scheduler: scoreboard bench; expected line-buffer writes queued by stimulus, popped by a monitor.
module tb_sprite_line_scheduler;
  logic clk = 0, reset_n = 0, line_start = 0, attr_we = 0, attr_en = 0, attr_flip = 0;
  logic [9:0] next_row = 0, attr_x = 0, attr_y = 0;
  logic [2:0] attr_idx = 0, rom_row, rom_col;
  logic [5:0] attr_num = 0, rom_sprite;
  logic [1:0] rom_pixel = 0, lb_data;
  logic [8:0] lb_addr;
  logic lb_write, busy, done, overflow, late;
  logic [10:0] q[$];
  int checks = 0, fails = 0;

  sprite_line_scheduler dut (
    .i_Clk(clk), .reset_n(reset_n), .line_start(line_start), .next_row(next_row),
    .attr_we(attr_we), .attr_idx(attr_idx), .attr_en(attr_en), .attr_flip(attr_flip),
    .attr_num(attr_num), .attr_x(attr_x), .attr_y(attr_y),
    .rom_sprite(rom_sprite), .rom_row(rom_row), .rom_col(rom_col), .rom_pixel(rom_pixel),
    .lb_write(lb_write), .lb_addr(lb_addr), .lb_data(lb_data),
    .busy(busy), .done(done), .overflow(overflow), .late(late)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] pix(input int s, input int r, input int c);
    return 2'((s + r + c) & 3);
  endfunction

  // Synchronous ROM: data one cycle after the address.
  always @(posedge clk) rom_pixel <= pix(int'(rom_sprite), int'(rom_row), int'(rom_col));

  always @(negedge clk) begin
    logic [10:0] e;
    if (lb_write) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL lb_write unexpected: got addr=%0d data=%0d, want no write", lb_addr, lb_data);
      end else begin
        e = q.pop_front();
        if ({lb_addr, lb_data} !== e) begin
          fails++;
          $display("FAIL lb_write: got addr=%0d data=%0d, want addr=%0d data=%0d",
                   lb_addr, lb_data, e[10:2], e[1:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic push_sprite(input int num, input int row, input int x2, input int lo,
                             input int hi, input bit fl);
    for (int c = lo; c <= hi; c++) begin
      int rc;
      logic [1:0] p;
`ifdef SPRITE_SCHED_HFLIP_EN
      rc = fl ? 7 - c : c;
`else
      rc = fl ? c : c;
`endif
      p = pix(num, row, rc);
      if (p != 0) q.push_back({9'((x2 + c) % 512), p});
    end
  endtask

  task automatic wattr(input int i, input bit en, input bit fl, input int num, input int x,
                       input int y);
    @(negedge clk);
    attr_we = 1; attr_idx = 3'(i); attr_en = en; attr_flip = fl;
    attr_num = 6'(num); attr_x = 10'(x); attr_y = 10'(y);
    @(negedge clk);
    attr_we = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  task automatic start_line(input int row, output int n);
    next_row = 10'(row);
    @(negedge clk);
    line_start = 1;
    @(negedge clk);
    line_start = 0;
    n = 1;
  endtask

  task automatic wait_done(input string nm, input int n0, input int exp_n);
    int n = n0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, n, exp_n);
  endtask

  task automatic run_line(input string nm, input int row, input int exp_n, input int exp_ovf);
    int n;
    start_line(row, n);
    wait_done(nm, n, exp_n);
    @(negedge clk);
    chk({nm, "_overflow"}, int'(overflow), exp_ovf);
    chk({nm, "_pending"}, q.size(), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_late", int'(late), 0);
    chk("rst_lb", int'({lb_write, lb_addr, lb_data}), 0);
    chk("rst_rom", int'({rom_sprite, rom_row, rom_col}), 0);

    wattr(2, 1, 0, 5, 100, 40);
    push_sprite(5, 3, 50, 0, 7, 0);
    run_line("basic", 47, 18, 0);
    chk("hold_sprite", int'(rom_sprite), 5);
    chk("hold_row", int'(rom_row), 3);
    chk("hold_col", int'(rom_col), 7);
    chk("idle_busy", int'(busy), 0);

    run_line("dy16", 56, 9, 0);
    run_line("above", 39, 9, 0);

    do_reset();
    for (int i = 0; i < 6; i++) wattr(i, 1, 0, 10 + i, 200 + 16 * i, 10 - i);
    for (int i = 3; i >= 0; i--) push_sprite(10 + i, i >> 1, 100 + 8 * i, 0, 7, 0);
    run_line("six", 10, 42, 1);

    do_reset();
    wattr(0, 1, 0, 1, 1020, 0);
    push_sprite(1, 0, 510, 0, 7, 0);
    run_line("xwrap", 0, 18, 0);

    wattr(0, 1, 0, 2, 0, 1020);
    push_sprite(2, 3, 0, 0, 7, 0);
    run_line("ywrap", 3, 18, 0);

    wattr(0, 1, 1, 3, 20, 0);
    push_sprite(3, 0, 10, 0, 7, 1);
    run_line("flip", 0, 18, 0);

    do_reset();
    wattr(2, 1, 0, 5, 100, 40);
    push_sprite(5, 3, 50, 0, 4, 0);
    start_line(47, n);
    while (n < 14) begin
      @(negedge clk);
      n++;
    end
    push_sprite(5, 3, 50, 0, 7, 0);
    line_start = 1;
    @(negedge clk);
    line_start = 0;
    chk("abort_late", int'(late), 1);
    chk("abort_lbw", int'(lb_write), 0);
    wait_done("abort", 1, 18);
    @(negedge clk);
    chk("abort_pending", q.size(), 0);

    push_sprite(5, 3, 50, 0, 3, 0);
    start_line(47, n);
    while (n < 14) begin
      @(negedge clk);
      n++;
    end
    reset_n = 0;
    @(negedge clk);
    chk("mrst_lbw", int'(lb_write), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_rom", int'({rom_sprite, rom_row, rom_col}), 0);
    chk("mrst_lb", int'({lb_addr, lb_data}), 0);
    chk("mrst_flags", int'({done, overflow, late}), 0);
    reset_n = 1;
    repeat (2) @(negedge clk);
    chk("mrst_pending", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/sprite_line_scheduler.md
SPRITE_LINE_SCHEDULER -- requirements
Module: sprite_line_scheduler

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 8, giving the number of sprite attribute entries (index width 3).
REQ-002 SHALL have parameter MAX_PER_LINE, default 4, giving the number of sprites drawn per line; further hits are dropped.
REQ-003 SHALL use one clock; reset is synchronous and active-low: i_Clk input 1, rising-edge clock; reset_n input 1, synchronous active-low reset.
REQ-004 SHALL have ports:
- line_start input 1: one-cycle pulse at hblank start.
- next_row input 10: row to be built.
- attr_we input 1: attribute write strobe.
- attr_idx input 3: entry index.
- attr_en input 1: entry enable.
- attr_flip input 1: horizontal flip.
- attr_num input 6: sprite number.
- attr_x input 10, attr_y input 10: sprite top-left position.
- rom_sprite output 6, rom_row output 3, rom_col output 3: SpriteROM address.
- rom_pixel input 2: ROM data, valid 1 cycle after address.
- lb_write output 1, lb_addr output 9, lb_data output 2: line-buffer write port (half-resolution x).
- busy output 1, done output 1 (one-cycle pulse), overflow output 1, late output 1 (one-cycle pulse).

Function
REQ-005 SHALL write attr_* into entry attr_idx on any cycle with attr_we=1, including while busy; the write is visible on the next cycle.
REQ-006 SHALL implement states IDLE, SCAN, FETCH, DONE: IDLE->SCAN on line_start; SCAN->FETCH after the last entry when hits>0; SCAN->DONE when hits=0; FETCH->DONE after the drain cycle; DONE->IDLE unconditionally.
REQ-007 SCAN SHALL examine one entry per cycle, index 0 to NUM_SPRITES-1. An entry is a hit when attr_en=1 and (next_row - attr_y) mod 1024 < 16.
REQ-008 Each hit SHALL be captured (num, x[9:1], dy[3:1], flip) into a hit list. Attribute writes after capture SHALL NOT affect that line.
REQ-009 Once MAX_PER_LINE hits are held, further hits SHALL be dropped and overflow SHALL be set. overflow is updated in DONE and holds until the next DONE.
REQ-010 FETCH SHALL process hits from highest to lowest index so that the lower index has priority, issuing 8 columns per hit, one per cycle, with no bubbles between hits.
REQ-011 For column c SHALL drive rom_sprite=num, rom_row=dy[3:1], rom_col=c. One cycle later it SHALL drive lb_addr=(x[9:1]+c) mod 512, lb_data=rom_pixel, and lb_write=1 only if rom_pixel!=0 (0 is transparent).
REQ-012 Worst-case latency SHALL be NUM_SPRITES + 8*MAX_PER_LINE + 1 drain + 1 DONE = 42 cycles from line_start to done.
REQ-013 busy SHALL be 1 in SCAN, FETCH and DONE. done SHALL pulse in DONE.
REQ-014 line_start while busy SHALL abort the current line (no further lb_write), pulse late, clear the hit list, and restart SCAN at entry 0 on the next cycle.
REQ-015 In IDLE, lb_write SHALL be 0 and the ROM address outputs SHALL hold their last value.

Reset
REQ-016 With reset_n=0 at a clock edge: state=IDLE; all attribute entries attr_en=0 (others 0); hit list empty; busy, done, overflow, late and lb_write=0; rom_*=0; lb_addr=0; lb_data=0.
REQ-017 Reset mid-FETCH SHALL suppress any pending pipelined lb_write in the same cycle.

Configuration
REQ-018 With SPRITE_SCHED_HFLIP_EN defined, a hit with flip=1 SHALL use rom_col=7-c while lb_addr stays x[9:1]+c. Without it, attr_flip SHALL be ignored (port retained) and rom_col=c always.

Structure
REQ-019 Package sprite_sched_pkg SHALL hold the state enum, the attribute struct (en, flip, num, x, y), the hit struct, and constants SPRITE_H=16 and LB_AW=9.
REQ-020 The attribute storage SHALL be the sub-module sprite_attr_table (NUM_SPRITES-entry register file: one write port, one combinational read port, synchronous active-low reset).

Verification
REQ-021 Entry 2 = {en=1, num=5, x=100, y=40}, next_row=47, line_start: 8 ROM reads with rom_sprite=5 and rom_row=3; non-zero pixels written at lb_addr 50..57; done at cycle 8+8+1+1=18.
REQ-022 Same entry with next_row=56 (dy=16) and next_row=39: no lb_write; done 9 cycles after line_start; overflow=0.
REQ-023 Six enabled entries all hitting row 10: exactly 4 sprites fetched (entries 0..3, order 3,2,1,0); overflow=1 after done.
REQ-024 Entry with x=1020: lb_addr wraps 510, 511, 0..5. Entry with y=1020, next_row=3: hit with dy=7, rom_row=3.
REQ-025 line_start re-asserted 5 cycles into FETCH: late pulses, no lb_write the next cycle, full rescan, and done at the normal latency from the second line_start. reset_n=0 mid-FETCH: all outputs at reset values on the next edge.
REQ-026 With SPRITE_SCHED_HFLIP_EN and flip=1: rom_col sequence 7..0 paired with lb_addr x/2+0..7. Without the macro: rom_col 0..7.
